sram_port_arbiter: RTL and testbench

//  Shares one SRAM-like memory port between the pipeline's instruction-fetch requester (F stage)
//  and data requester (M stage). Each side uses a req/addr_ok/data_ok handshake.

---
 rtl/sram_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Shares one SRAM-like memory port between the instruction-fetch
//            requester (F stage) and the data requester (M stage). Each side
//            uses a req/addr_ok/data_ok handshake. Only one transaction is
//            outstanding at a time. Data has priority, with a starvation guard
//            that forces a fetch grant after STARVE_LIMIT consecutive data
//            grants. A fetch response can be cancelled on exception redirect.
// Ports    :
//   clk, rst                 clock (rising edge), async active-low reset
//   inst_req/inst_addr       fetch request, held until inst_addr_ok
//   inst_cancel              pulse: drop the response of the current fetch
//   inst_addr_ok/data_ok     fetch accept / read data valid
//   inst_rdata               fetch read data (mem_rdata pass-through)
//   data_req/wr/wen/addr/wdata  load/store request, held until data_addr_ok
//   data_addr_ok/data_ok     data accept / load data valid or store done
//   data_rdata               load data (mem_rdata pass-through)
//   mem_req/wr/wen/addr/wdata   registered request to memory
//   mem_addr_ok/data_ok/rdata   memory handshake and read data
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // fetch side
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_cancel,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // data side
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // memory side
  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int c_CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR_I = 3'd1,
    S_ADDR_D = 3'd2,
    S_WAIT_I = 3'd3,
    S_WAIT_D = 3'd4
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_starveCnt;
  logic                r_cancelFlag;
  logic                r_memReq;
  logic                r_memWr;
  logic [3:0]          r_memWen;
  logic [ADDR_W-1:0]   r_memAddr;
  logic [DATA_W-1:0]   r_memWdata;

  logic w_arbitrate;
  logic w_starved;
  logic w_grantData;
  logic w_grantInst;

  // Arbitration happens when idle, or in the cycle a transaction completes so
  // the next grant follows with no idle bubble.
  assign w_arbitrate = (r_state == S_IDLE) ||
                       (((r_state == S_WAIT_I) || (r_state == S_WAIT_D)) && mem_data_ok);
  assign w_starved   = inst_req && (r_starveCnt == c_STARVE_MAX);
  assign w_grantData = w_arbitrate && data_req && !w_starved;
  assign w_grantInst = w_arbitrate && inst_req && !(data_req && !w_starved);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_starveCnt  <= '0;
      r_cancelFlag <= 1'b0;
      r_memReq     <= 1'b0;
      r_memWr      <= 1'b0;
      r_memWen     <= 4'b0;
      r_memAddr    <= '0;
      r_memWdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_WAIT_I, S_WAIT_D: begin
          if (w_arbitrate) begin
            if (w_grantData) begin
              r_state    <= S_ADDR_D;
              r_memReq   <= 1'b1;
              r_memWr    <= data_wr;
              r_memWen   <= data_wr ? data_wen : 4'b0;
              r_memAddr  <= data_addr;
              r_memWdata <= data_wdata;
            end else if (w_grantInst) begin
              r_state    <= S_ADDR_I;
              r_memReq   <= 1'b1;
              r_memWr    <= 1'b0;
              r_memWen   <= 4'b0;
              r_memAddr  <= inst_addr;
            end else begin
              r_state    <= S_IDLE;
              r_memReq   <= 1'b0;
            end
          end
        end
        S_ADDR_I: begin
          if (mem_addr_ok) begin
            r_state  <= S_WAIT_I;
            r_memReq <= 1'b0;
          end
        end
        S_ADDR_D: begin
          if (mem_addr_ok) begin
            r_state  <= S_WAIT_D;
            r_memReq <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_memReq <= 1'b0;
        end
      endcase

      // Counts data grants won while fetch is waiting; any fetch grant or a
      // quiet fetch side resets it.
      if (!inst_req || w_grantInst) begin
        r_starveCnt <= '0;
      end else if (w_grantData && (r_starveCnt != c_STARVE_MAX)) begin
        r_starveCnt <= r_starveCnt + c_CNT_W'(1);
      end

      // The flag marks the current fetch as redirected away; it lives until
      // that fetch's response arrives so the response can be swallowed.
      if ((r_state == S_WAIT_I) && mem_data_ok) begin
        r_cancelFlag <= 1'b0;
      end else if (inst_cancel && ((r_state == S_ADDR_I) || (r_state == S_WAIT_I) ||
                                   ((r_state == S_IDLE) && w_grantInst))) begin
        r_cancelFlag <= 1'b1;
      end
    end
  end

  assign mem_req      = r_memReq;
  assign mem_wr       = r_memWr;
  assign mem_wen      = r_memWen;
  assign mem_addr     = r_memAddr;
  assign mem_wdata    = r_memWdata;

  assign inst_addr_ok = (r_state == S_ADDR_I) && mem_addr_ok;
  assign data_addr_ok = (r_state == S_ADDR_D) && mem_addr_ok;
  // A same-cycle cancel must also suppress the response it coincides with.
  assign inst_data_ok = (r_state == S_WAIT_I) && mem_data_ok && !r_cancelFlag && !inst_cancel;
  assign data_data_ok = (r_state == S_WAIT_D) && mem_data_ok;

  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Purpose  : Self-checking bench for sram_port_arbiter: directed scenarios
//            plus a randomized run against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_cancel;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              data_req;
  logic              data_wr;
  logic [3:0]        data_wen;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;
  logic              mem_req;
  logic              mem_wr;
  logic [3:0]        mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  int passCnt  = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_cancel (inst_cancel),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_wen    (data_wen),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata)
  );

  // Step to 1 time unit after the next rising edge; inputs are driven there
  // and outputs are sampled one more unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    inst_req    = 1'b0;
    inst_addr   = '0;
    inst_cancel = 1'b0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_wen    = 4'b0;
    data_addr   = '0;
    data_wdata  = '0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idleInputs();
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1; data_wen = 4'hF;
    data_addr = 32'h1234_5678; data_wdata = 32'hFFFF_FFFF;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    tick(); tick(); #1;
    totalCnt++; if (mem_req !== 1'b0) $display("FAIL reset mem_req got %0h want 0", mem_req); else passCnt++;
    totalCnt++; if (mem_wr !== 1'b0) $display("FAIL reset mem_wr got %0h want 0", mem_wr); else passCnt++;
    totalCnt++; if (mem_wen !== 4'h0) $display("FAIL reset mem_wen got %0h want 0", mem_wen); else passCnt++;
    totalCnt++; if (mem_addr !== 32'h0) $display("FAIL reset mem_addr got %0h want 0", mem_addr); else passCnt++;
    totalCnt++; if (mem_wdata !== 32'h0) $display("FAIL reset mem_wdata got %0h want 0", mem_wdata); else passCnt++;
    totalCnt++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0)
      $display("FAIL reset handshakes got %b want 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); else passCnt++;
    idleInputs();
    #2 rst = 1'b1;
    tick(); tick();
  endtask

  task automatic test_fetch_only();
    tick(); inst_req = 1'b1; inst_addr = 32'hBFC0_0000; #1;
    totalCnt++; if (mem_req !== 1'b0) $display("FAIL fetch req_cycle mem_req got %0h want 0", mem_req); else passCnt++;
    tick(); mem_addr_ok = 1'b1; #1;
    totalCnt++; if (mem_req !== 1'b1) $display("FAIL fetch mem_req got %0h want 1", mem_req); else passCnt++;
    totalCnt++; if (mem_addr !== 32'hBFC0_0000) $display("FAIL fetch mem_addr got %0h want bfc00000", mem_addr); else passCnt++;
    totalCnt++; if (mem_wr !== 1'b0) $display("FAIL fetch mem_wr got %0h want 0", mem_wr); else passCnt++;
    totalCnt++; if (inst_addr_ok !== 1'b1) $display("FAIL fetch inst_addr_ok got %0h want 1", inst_addr_ok); else passCnt++;
    totalCnt++; if (data_addr_ok !== 1'b0) $display("FAIL fetch data_addr_ok got %0h want 0", data_addr_ok); else passCnt++;
    tick(); inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h2408_0001; #1;
    totalCnt++; if (mem_req !== 1'b0) $display("FAIL fetch wait mem_req got %0h want 0", mem_req); else passCnt++;
    totalCnt++; if (inst_data_ok !== 1'b1) $display("FAIL fetch inst_data_ok got %0h want 1", inst_data_ok); else passCnt++;
    totalCnt++; if (inst_rdata !== 32'h2408_0001) $display("FAIL fetch inst_rdata got %0h want 24080001", inst_rdata); else passCnt++;
    totalCnt++; if (data_data_ok !== 1'b0) $display("FAIL fetch data_data_ok got %0h want 0", data_data_ok); else passCnt++;
    tick(); mem_data_ok = 1'b0; #1;
    totalCnt++; if (inst_data_ok !== 1'b0) $display("FAIL fetch data_ok_pulse got %0h want 0", inst_data_ok); else passCnt++;
  endtask

  task automatic test_simultaneous();
    tick();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
    data_req = 1'b1; data_wr = 1'b1; data_wen = 4'b0011; data_addr = 32'h8000_0010; data_wdata = 32'h0000_1234;
    #1;
    tick(); mem_addr_ok = 1'b1; #1;
    totalCnt++; if (mem_wen !== 4'b0011) $display("FAIL simul mem_wen got %b want 0011", mem_wen); else passCnt++;
    totalCnt++; if (mem_addr !== 32'h8000_0010) $display("FAIL simul mem_addr got %0h want 80000010", mem_addr); else passCnt++;
    totalCnt++; if (mem_wdata !== 32'h0000_1234) $display("FAIL simul mem_wdata got %0h want 1234", mem_wdata); else passCnt++;
    totalCnt++; if (mem_wr !== 1'b1) $display("FAIL simul mem_wr got %0h want 1", mem_wr); else passCnt++;
    totalCnt++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) $display("FAIL simul addr_ok d/i got %b want 10", {data_addr_ok, inst_addr_ok}); else passCnt++;
    tick(); data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; #1;
    totalCnt++; if (data_data_ok !== 1'b1) $display("FAIL simul data_data_ok got %0h want 1", data_data_ok); else passCnt++;
    tick(); mem_data_ok = 1'b0; mem_addr_ok = 1'b1; #1;
    totalCnt++; if (mem_req !== 1'b1) $display("FAIL simul no_bubble mem_req got %0h want 1", mem_req); else passCnt++;
    totalCnt++; if (mem_addr !== 32'hBFC0_0010) $display("FAIL simul fetch mem_addr got %0h want bfc00010", mem_addr); else passCnt++;
    totalCnt++; if ({mem_wr, mem_wen} !== 5'b0) $display("FAIL simul fetch wr/wen got %b want 00000", {mem_wr, mem_wen}); else passCnt++;
    totalCnt++; if (inst_addr_ok !== 1'b1) $display("FAIL simul inst_addr_ok got %0h want 1", inst_addr_ok); else passCnt++;
    tick(); inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h3C1D_8000; #1;
    totalCnt++; if (inst_data_ok !== 1'b1) $display("FAIL simul inst_data_ok got %0h want 1", inst_data_ok); else passCnt++;
    totalCnt++; if (inst_rdata !== 32'h3C1D_8000) $display("FAIL simul inst_rdata got %0h want 3c1d8000", inst_rdata); else passCnt++;
    tick(); mem_data_ok = 1'b0; #1;
  endtask

  task automatic test_starvation();
    bit held;
    int n;
    int firstCyc;
    int lastCyc;
    bit order[8];
    bit expOrd[6];
    held = 1'b0; n = 0; firstCyc = -1; lastCyc = -1;
    expOrd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tick();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
    data_req = 1'b1; data_wr = 1'b0; data_wen = 4'b0; data_addr = 32'h8000_0200;
    #1;
    for (int c = 0; c < 80 && n < 6; c++) begin
      tick();
      mem_data_ok = held; held = 1'b0; mem_addr_ok = mem_req;
      #1;
      if (inst_addr_ok && n < 8) begin order[n] = 1'b1; n++; end
      if (data_addr_ok && n < 8) begin order[n] = 1'b0; n++; end
      if (inst_addr_ok || data_addr_ok) begin
        if (firstCyc < 0) firstCyc = c;
        lastCyc = c;
      end
      if (mem_addr_ok) held = 1'b1;
    end
    totalCnt++; if (n !== 6) $display("FAIL starve grant_count got %0d want 6 (cycle budget)", n); else passCnt++;
    for (int i = 0; i < 6; i++) begin
      totalCnt++; if (order[i] !== expOrd[i]) $display("FAIL starve grant%0d is_fetch got %0d want %0d", i, order[i], expOrd[i]); else passCnt++;
    end
    totalCnt++; if (lastCyc - firstCyc !== 10) $display("FAIL starve span got %0d want 10", lastCyc - firstCyc); else passCnt++;
    tick(); inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = held; #1;
    tick(); mem_data_ok = 1'b0; #1;
  endtask

  task automatic test_cancel();
    // cancel while waiting for the response
    tick(); inst_req = 1'b1; inst_addr = 32'hBFC0_0200; #1;
    tick(); mem_addr_ok = 1'b1; #1;
    totalCnt++; if (inst_addr_ok !== 1'b1) $display("FAIL cancel addr_ok got %0h want 1", inst_addr_ok); else passCnt++;
    tick(); inst_req = 1'b0; mem_addr_ok = 1'b0; inst_cancel = 1'b1; #1;
    tick(); inst_cancel = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
    totalCnt++; if (inst_data_ok !== 1'b0) $display("FAIL cancel wait_suppress got %0h want 0", inst_data_ok); else passCnt++;
    totalCnt++; if (data_data_ok !== 1'b0) $display("FAIL cancel data_data_ok got %0h want 0", data_data_ok); else passCnt++;
    // next fetch is delivered normally
    tick(); mem_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC0_0204; #1;
    tick(); mem_addr_ok = 1'b1; #1;
    tick(); inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0B0B; #1;
    totalCnt++; if (inst_data_ok !== 1'b1) $display("FAIL cancel next_data_ok got %0h want 1", inst_data_ok); else passCnt++;
    totalCnt++; if (inst_rdata !== 32'h0000_0B0B) $display("FAIL cancel next_rdata got %0h want b0b", inst_rdata); else passCnt++;
    // cancel in the grant cycle, request held through a stalled accept
    tick(); mem_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC0_0300; inst_cancel = 1'b1; #1;
    tick(); inst_cancel = 1'b0; #1;
    totalCnt++; if (mem_req !== 1'b1) $display("FAIL cancel grant_held mem_req got %0h want 1", mem_req); else passCnt++;
    tick(); mem_addr_ok = 1'b1; #1;
    tick(); inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; #1;
    totalCnt++; if (inst_data_ok !== 1'b0) $display("FAIL cancel grant_suppress got %0h want 0", inst_data_ok); else passCnt++;
    tick(); mem_data_ok = 1'b0; #1;
  endtask

  task automatic test_backpressure();
    tick();
    data_req = 1'b1; data_wr = 1'b1; data_wen = 4'b0110; data_addr = 32'h8000_0040; data_wdata = 32'hA5A5_5A5A;
    #1;
    for (int i = 0; i < 5; i++) begin
      tick(); mem_addr_ok = 1'b0; #1;
      totalCnt++; if (mem_req !== 1'b1) $display("FAIL bp%0d mem_req got %0h want 1", i, mem_req); else passCnt++;
      totalCnt++; if ({mem_addr, mem_wdata, mem_wen} !== {32'h8000_0040, 32'hA5A5_5A5A, 4'b0110})
        $display("FAIL bp%0d fields got %0h/%0h/%b want 80000040/a5a55a5a/0110", i, mem_addr, mem_wdata, mem_wen); else passCnt++;
      totalCnt++; if (data_addr_ok !== 1'b0) $display("FAIL bp%0d data_addr_ok got %0h want 0", i, data_addr_ok); else passCnt++;
    end
    tick(); mem_addr_ok = 1'b1; #1;
    totalCnt++; if (data_addr_ok !== 1'b1) $display("FAIL bp accept data_addr_ok got %0h want 1", data_addr_ok); else passCnt++;
    tick(); data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; #1;
    totalCnt++; if (data_data_ok !== 1'b1) $display("FAIL bp data_data_ok got %0h want 1", data_data_ok); else passCnt++;
    tick(); mem_data_ok = 1'b0; #1;
  endtask

  task automatic test_async_reset();
    tick(); data_req = 1'b1; data_wr = 1'b1; data_wen = 4'hF; data_addr = 32'h8000_0100; data_wdata = 32'hCAFE_F00D; #1;
    tick(); mem_addr_ok = 1'b1; #1;
    tick(); data_req = 1'b0; mem_addr_ok = 1'b0; #1;
    #2; rst = 1'b0; mem_data_ok = 1'b1; #1;
    totalCnt++; if ({mem_req, mem_wr, mem_wen} !== 6'b0) $display("FAIL areset req/wr/wen got %b want 0", {mem_req, mem_wr, mem_wen}); else passCnt++;
    totalCnt++; if ({mem_addr, mem_wdata} !== 64'h0) $display("FAIL areset addr/wdata got %0h/%0h want 0", mem_addr, mem_wdata); else passCnt++;
    totalCnt++; if (data_data_ok !== 1'b0) $display("FAIL areset data_data_ok got %0h want 0", data_data_ok); else passCnt++;
    #1; rst = 1'b1; mem_data_ok = 1'b0;
    tick(); inst_req = 1'b1; inst_addr = 32'hBFC0_0040; #1;
    tick(); mem_addr_ok = 1'b1; #1;
    totalCnt++; if (inst_addr_ok !== 1'b1) $display("FAIL areset fresh addr_ok got %0h want 1", inst_addr_ok); else passCnt++;
    totalCnt++; if (mem_addr !== 32'hBFC0_0040) $display("FAIL areset fresh mem_addr got %0h want bfc00040", mem_addr); else passCnt++;
    tick(); inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1111_2222; #1;
    totalCnt++; if (inst_data_ok !== 1'b1) $display("FAIL areset fresh data_ok got %0h want 1", inst_data_ok); else passCnt++;
    totalCnt++; if (data_data_ok !== 1'b0) $display("FAIL areset lost_resp got %0h want 0", data_data_ok); else passCnt++;
    tick(); mem_data_ok = 1'b0; #1;
  endtask

  // Random traffic checked against a transaction-level model: one outstanding
  // transaction record, arbitration decided from the request lines and the
  // starvation count at each idle/completion point.
  task automatic test_random();
    bit oValid, oInst, oAcc, oCanc, oWr;
    logic [31:0] oAddr, oWdata;
    logic [3:0] oWen;
    int starve;
    bit fPend, dPend, memBusy;
    int memCnt;
    logic [31:0] fA, dA, dWd;
    logic dW;
    logic [3:0] dWe;
    bit expReq, expIAok, expDAok, expIDok, expDDok, arb, wasIdle, winI, winD, live;
    oValid = 0; oInst = 0; oAcc = 0; oCanc = 0; oWr = 0; oAddr = 0; oWdata = 0; oWen = 0;
    starve = 0; fPend = 0; dPend = 0; memBusy = 0; memCnt = 0;
    fA = 0; dA = 0; dWd = 0; dW = 0; dWe = 0;
    idleInputs();
    tick(); rst = 1'b0; #2; rst = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      live = (cyc < 2800);
      if (!fPend && live && $urandom_range(0, 99) < 40) begin
        fPend = 1; fA = $urandom & 32'hFFFF_FFFC;
      end
      if (!dPend && live && $urandom_range(0, 99) < 45) begin
        dPend = 1; dW = 1'($urandom_range(0, 1)); dA = $urandom & 32'hFFFF_FFFC; dWd = $urandom;
        dWe = dW ? 4'($urandom_range(1, 15)) : 4'h0;
      end
      inst_req = fPend; inst_addr = fA;
      data_req = dPend; data_wr = dW; data_wen = dWe; data_addr = dA; data_wdata = dWd;
      inst_cancel = live && ($urandom_range(0, 99) < 6);
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      if (memBusy) begin
        if (memCnt == 0) begin mem_data_ok = 1'b1; mem_rdata = $urandom; memBusy = 0; end
        else memCnt--;
      end else if (mem_req) begin
        if ($urandom_range(0, 99) < 60) begin mem_addr_ok = 1'b1; memBusy = 1; memCnt = $urandom_range(0, 2); end
      end else if ($urandom_range(0, 99) < 5) begin
        mem_data_ok = 1'b1; mem_rdata = $urandom;
      end
      #1;
      expReq  = oValid && !oAcc;
      expIAok = expReq && oInst && mem_addr_ok;
      expDAok = expReq && !oInst && mem_addr_ok;
      expIDok = oValid && oAcc && oInst && mem_data_ok && !oCanc && !inst_cancel;
      expDDok = oValid && oAcc && !oInst && mem_data_ok;
      totalCnt++; if (mem_req !== expReq) $display("FAIL rnd%0d mem_req got %0h want %0h", cyc, mem_req, expReq); else passCnt++;
      if (expReq) begin
        totalCnt++; if ({mem_addr, mem_wr, mem_wen} !== {oAddr, oWr, oWen})
          $display("FAIL rnd%0d fields got %0h/%0h/%b want %0h/%0h/%b", cyc, mem_addr, mem_wr, mem_wen, oAddr, oWr, oWen); else passCnt++;
        if (!oInst) begin
          totalCnt++; if (mem_wdata !== oWdata) $display("FAIL rnd%0d mem_wdata got %0h want %0h", cyc, mem_wdata, oWdata); else passCnt++;
        end
      end
      totalCnt++; if (inst_addr_ok !== expIAok) $display("FAIL rnd%0d inst_addr_ok got %0h want %0h", cyc, inst_addr_ok, expIAok); else passCnt++;
      totalCnt++; if (data_addr_ok !== expDAok) $display("FAIL rnd%0d data_addr_ok got %0h want %0h", cyc, data_addr_ok, expDAok); else passCnt++;
      totalCnt++; if (inst_data_ok !== expIDok) $display("FAIL rnd%0d inst_data_ok got %0h want %0h", cyc, inst_data_ok, expIDok); else passCnt++;
      totalCnt++; if (data_data_ok !== expDDok) $display("FAIL rnd%0d data_data_ok got %0h want %0h", cyc, data_data_ok, expDDok); else passCnt++;
      if (expIDok) begin
        totalCnt++; if (inst_rdata !== mem_rdata) $display("FAIL rnd%0d inst_rdata got %0h want %0h", cyc, inst_rdata, mem_rdata); else passCnt++;
      end
      if (expDDok) begin
        totalCnt++; if (data_rdata !== mem_rdata) $display("FAIL rnd%0d data_rdata got %0h want %0h", cyc, data_rdata, mem_rdata); else passCnt++;
      end
      // model update for the coming edge
      arb     = !oValid || (oAcc && mem_data_ok);
      wasIdle = !oValid;
      if (expIAok) fPend = 0;
      if (expDAok) dPend = 0;
      if (expReq && mem_addr_ok) oAcc = 1;
      if (inst_cancel && oValid && oInst) oCanc = 1;
      winD = arb && data_req && !(inst_req && starve == STARVE_LIMIT);
      winI = arb && inst_req && !winD;
      if (arb) begin
        oValid = winD || winI;
        oAcc   = 0;
        oCanc  = 0;
        if (winD) begin
          oInst = 0; oAddr = data_addr; oWr = data_wr; oWen = data_wr ? data_wen : 4'h0; oWdata = data_wdata;
        end else if (winI) begin
          oInst = 1; oAddr = inst_addr; oWr = 0; oWen = 4'h0; oCanc = inst_cancel && wasIdle;
        end
      end
      if (!inst_req || winI) starve = 0;
      else if (winD && starve < STARVE_LIMIT) starve++;
    end
    inst_req = 1'b0; data_req = 1'b0; inst_cancel = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    tick(); #1;
    totalCnt++; if (mem_req !== 1'b0) $display("FAIL rnd drained mem_req got %0h want 0", mem_req); else passCnt++;
  endtask

  initial begin
    idleInputs();
    rst = 1'b0;
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_cancel();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
`default_nettype wire
